lsu_byte_sequencer: RTL and testbench

- Load/store unit directly upstream of the byte-wide data memory in the MEM stage.
- Accepts one byte, halfword or word request from the EX/MEM boundary.
- Serialises the request into little-endian single-byte memory beats, then returns a sign- or zero-extended 32-bit result.
- Stalls the pipeline while the request is in flight. Misaligned and illegal requests are rejected without touching memory.

---
 rtl/lsu_byte_sequencer_if.sv | 39 +++
 rtl/lsu_byte_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_byte_sequencer_if.sv
// lsu_byte_sequencer_if: request/response handshake plus byte-wide memory port
// for the MEM-stage load/store byte sequencer.
// The slave modport is the sequencer itself.
// The master modport is the pipeline-and-memory side that drives it.
interface lsu_byte_sequencer_if #(
  parameter int ADDR_W = 5
) ();
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [31:0]       req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              resp_valid_o;
  logic [31:0]       resp_rdata_o;
  logic              misalign_o;
  logic              fault_o;
  logic              stall_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [7:0]        mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, misalign_o, fault_o,
           stall_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, misalign_o, fault_o,
           stall_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: splits byte/half/word loads and stores into
// little-endian single-byte memory beats.
// Loads return a sign- or zero-extended 32-bit result.
// Misaligned or illegal-size requests are answered without touching memory.
// Optional macro LSU_BOUNDS_CHECK_EN rejects accesses that fall outside
// MEM_DEPTH (fault_o). Without it, addresses wrap modulo MEM_DEPTH.
module lsu_byte_sequencer #(
  parameter int MEM_DEPTH = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  lsu_byte_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       acc_q, acc_d;
  logic              pend_q, pend_d;
  logic [1:0]        pend_lane_q, pend_lane_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              misalign_q, misalign_d;
  logic              fault_q, fault_d;
  logic              size_bad;
  logic              out_of_bounds;
  logic [31:0]       ext_data;

  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      2'b00:   last_beat = 2'd0;
      2'b01:   last_beat = 2'd1;
      default: last_beat = 2'd3;
    endcase
  endfunction

`ifdef LSU_BOUNDS_CHECK_EN
  logic [31:0] last_addr;

  // Flag requests whose last byte lies past the end of the data memory
  always_comb begin
    last_addr     = 32'(bus.req_addr_i[ADDR_W-1:0]) + 32'(last_beat(bus.req_size_i));
    out_of_bounds = (bus.req_addr_i[31:ADDR_W] != '0) || (last_addr >= 32'(MEM_DEPTH));
  end
`else
  logic        unused_addr_hi;
  logic [31:0] unused_depth;
  assign unused_addr_hi = ^bus.req_addr_i[31:ADDR_W];
  assign unused_depth   = 32'(MEM_DEPTH);

  // Without bounds checking the upper address bits are dropped and accesses wrap
  always_comb begin
    out_of_bounds = 1'b0;
  end
`endif

  // Alignment rules plus sign/zero extension of the assembled load data
  always_comb begin
    size_bad = (bus.req_size_i == 2'b11) ||
               ((bus.req_size_i == 2'b01) && bus.req_addr_i[0]) ||
               ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
    case (size_q)
      2'b00:   ext_data = uns_q ? {24'h0, acc_q[7:0]}  : {{24{acc_q[7]}}, acc_q[7:0]};
      2'b01:   ext_data = uns_q ? {16'h0, acc_q[15:0]} : {{16{acc_q[15]}}, acc_q[15:0]};
      default: ext_data = acc_q;
    endcase
  end

  // Next-state, beat sequencing, load capture and all outputs
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    pend_d      = 1'b0;
    pend_lane_d = beat_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    misalign_d  = misalign_q;
    fault_d     = fault_q;

    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.resp_rdata_o = 32'h0;
    bus.misalign_o   = 1'b0;
    bus.fault_o      = 1'b0;
    bus.stall_o      = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = 8'h00;
    bus.mem_we_o     = 1'b0;
    bus.mem_re_o     = 1'b0;

    if (pend_q) begin
      acc_d[{pend_lane_q, 3'b000} +: 8] = bus.mem_rdata_i;
    end

    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        bus.stall_o     = bus.req_valid_i;
        if (bus.req_valid_i) begin
          we_d       = bus.req_we_i;
          size_d     = bus.req_size_i;
          uns_d      = bus.req_unsigned_i;
          addr_d     = bus.req_addr_i[ADDR_W-1:0];
          wdata_d    = bus.req_wdata_i;
          misalign_d = size_bad;
          fault_d    = out_of_bounds;
          beat_d     = 2'd0;
          acc_d      = 32'h0;
          state_d    = (size_bad || out_of_bounds) ? RESP : XFER;
        end
      end
      XFER: begin
        // Strobes are qualified with rst_i so a reset arriving mid-transfer
        // suppresses the beat that would otherwise land on the reset edge.
        bus.stall_o    = 1'b1;
        bus.mem_addr_o = addr_q + ADDR_W'(beat_q);
        if (we_q) begin
          bus.mem_we_o    = rst_i;
          bus.mem_wdata_o = wdata_q[{beat_q, 3'b000} +: 8];
        end else begin
          bus.mem_re_o = rst_i;
          pend_d       = 1'b1;
        end
        if (beat_q == last_beat(size_q)) begin
          state_d = we_q ? RESP : DRAIN;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      DRAIN: begin
        bus.stall_o = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rst_i) begin
          bus.resp_valid_o = 1'b1;
          bus.misalign_o   = misalign_q;
          bus.fault_o      = fault_q;
          bus.resp_rdata_o = (we_q || misalign_q || fault_q) ? 32'h0 : ext_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      acc_q       <= 32'h0;
      pend_q      <= 1'b0;
      pend_lane_q <= 2'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      misalign_q  <= misalign_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb_lsu_byte_sequencer: directed self-checking bench for lsu_byte_sequencer
// with a 32-byte registered-read memory model.
// Honours LSU_BOUNDS_CHECK_EN for the out-of-range store scenario.
module tb_lsu_byte_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_init = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lsu_byte_sequencer_if #(.ADDR_W(5)) bus ();

  lsu_byte_sequencer #(.MEM_DEPTH(32), .ADDR_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte memory model: writes land on the edge, reads return one cycle later
  logic [7:0] mem [0:31];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      bus.mem_rdata_i <= 8'h00;
    end else begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      if (bus.mem_re_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end
  end

  // Per-cycle log of one transaction, index = cycles after acceptance
  logic       we_log    [0:12];
  logic       re_log    [0:12];
  logic [4:0] addr_log  [0:12];
  logic [7:0] wd_log    [0:12];
  logic       stall_log [0:12];
  logic       ready_log [0:12];
  int         resp_cyc;
  logic [31:0] resp_rdata;
  logic       resp_mis;
  logic       resp_fault;

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    for (int k = 0; k <= 12; k++) begin
      we_log[k] = 1'b0; re_log[k] = 1'b0; addr_log[k] = '0; wd_log[k] = '0;
      stall_log[k] = 1'b0; ready_log[k] = 1'b0;
    end
    resp_cyc = -1; resp_rdata = 32'h0; resp_mis = 1'b0; resp_fault = 1'b0;
    @(negedge clk);
    bus.req_we_i = we; bus.req_size_i = size; bus.req_unsigned_i = uns;
    bus.req_addr_i = addr; bus.req_wdata_i = wdata; bus.req_valid_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      #1;
      we_log[k] = bus.mem_we_o; re_log[k] = bus.mem_re_o; addr_log[k] = bus.mem_addr_o;
      wd_log[k] = bus.mem_wdata_o; stall_log[k] = bus.stall_o; ready_log[k] = bus.req_ready_o;
      if (bus.resp_valid_o) begin
        resp_cyc = k; resp_rdata = bus.resp_rdata_o;
        resp_mis = bus.misalign_o; resp_fault = bus.fault_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_init = 1'b1; bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0;
    bus.req_size_i = 2'b00; bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.req_ready_o); end
    checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.resp_valid_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall_o); end
    checks++; if ({bus.mem_we_o, bus.mem_re_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 00", {bus.mem_we_o, bus.mem_re_o}); end
    checks++; if ({bus.misalign_o, bus.fault_o, bus.resp_rdata_o} !== 34'h0) begin errors++; $display("[TB] FAIL reset_resp_fields: got %h expected 0", {bus.misalign_o, bus.fault_o, bus.resp_rdata_o}); end
    rst = 1'b1; mem_init = 1'b0;
  endtask

  task automatic test_store_word();
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF);
    checks++; if (resp_cyc !== 5) begin errors++; $display("[TB] FAIL store_word_latency: got %0d expected 5", resp_cyc); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if ({we_log[k], re_log[k], addr_log[k], wd_log[k], stall_log[k]} !== {1'b1, 1'b0, 5'(3 + k), exp_b[k-1], 1'b1}) begin
        errors++; $display("[TB] FAIL store_word_beat%0d: got we=%b re=%b addr=%h data=%h stall=%b expected we=1 re=0 addr=%h data=%h stall=1",
                           k, we_log[k], re_log[k], addr_log[k], wd_log[k], stall_log[k], 5'(3 + k), exp_b[k-1]);
      end
    end
    checks++; if ({resp_mis, resp_fault, resp_rdata} !== 34'h0) begin errors++; $display("[TB] FAIL store_word_resp: got %h expected 0", {resp_mis, resp_fault, resp_rdata}); end
    checks++; if ({stall_log[5], ready_log[5], we_log[5]} !== 3'b000) begin errors++; $display("[TB] FAIL store_word_resp_cycle: got stall/ready/we %b expected 000", {stall_log[5], ready_log[5], we_log[5]}); end
    checks++; if ({mem[7], mem[6], mem[5], mem[4]} !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL store_word_mem: got %h expected DEADBEEF", {mem[7], mem[6], mem[5], mem[4]}); end
  endtask

  task automatic test_loads();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h07, 32'h0);
    checks++; if (resp_cyc !== 3 || resp_rdata !== 32'hFFFFFFDE) begin errors++; $display("[TB] FAIL load_byte_signed: got cyc=%0d data=%h expected cyc=3 data=FFFFFFDE", resp_cyc, resp_rdata); end
    checks++; if ({re_log[1], we_log[1], addr_log[1], re_log[2], stall_log[2]} !== {1'b1, 1'b0, 5'h07, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL load_byte_beat: got re=%b we=%b addr=%h drain_re=%b drain_stall=%b expected 1 0 07 0 1", re_log[1], we_log[1], addr_log[1], re_log[2], stall_log[2]); end
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h07, 32'h0);
    checks++; if (resp_rdata !== 32'h000000DE) begin errors++; $display("[TB] FAIL load_byte_unsigned: got %h expected 000000DE", resp_rdata); end
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h06, 32'h0);
    checks++; if (resp_cyc !== 4 || resp_rdata !== 32'hFFFFDEAD) begin errors++; $display("[TB] FAIL load_half_signed: got cyc=%0d data=%h expected cyc=4 data=FFFFDEAD", resp_cyc, resp_rdata); end
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h04, 32'h0);
    checks++; if (resp_rdata !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL load_half_unsigned: got %h expected 0000BEEF", resp_rdata); end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    checks++; if (resp_cyc !== 6 || resp_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_word: got cyc=%0d data=%h expected cyc=6 data=DEADBEEF", resp_cyc, resp_rdata); end
    checks++; if ({stall_log[5], re_log[5], stall_log[6]} !== 3'b100) begin errors++; $display("[TB] FAIL load_word_drain: got stall5/re5/stall6 %b expected 100", {stall_log[5], re_log[5], stall_log[6]}); end
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h10, 32'h1234565A);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    checks++; if (resp_rdata !== 32'h0000005A) begin errors++; $display("[TB] FAIL load_byte_positive: got %h expected 0000005A", resp_rdata); end
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234ABCD);
    checks++; if ({mem[20], mem[19], mem[18], resp_cyc} !== {8'h00, 8'hAB, 8'hCD, 32'd3}) begin errors++; $display("[TB] FAIL store_half: got mem14..12=%h%h%h cyc=%0d expected 00ABCD cyc=3", mem[20], mem[19], mem[18], resp_cyc); end
  endtask

  task automatic test_misalign();
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h05, 32'h0);
    checks++; if ({resp_cyc, resp_mis, resp_fault, re_log[1], resp_rdata} !== {32'd1, 1'b1, 1'b0, 1'b0, 32'h0}) begin errors++; $display("[TB] FAIL misalign_half: got cyc=%0d mis=%b fault=%b re=%b data=%h expected cyc=1 mis=1 fault=0 re=0 data=0", resp_cyc, resp_mis, resp_fault, re_log[1], resp_rdata); end
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    checks++; if ({resp_cyc, resp_mis, resp_fault, re_log[1], resp_rdata} !== {32'd1, 1'b1, 1'b0, 1'b0, 32'h0}) begin errors++; $display("[TB] FAIL illegal_size: got cyc=%0d mis=%b fault=%b re=%b data=%h expected cyc=1 mis=1 fault=0 re=0 data=0", resp_cyc, resp_mis, resp_fault, re_log[1], resp_rdata); end
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0A, 32'hFFFFFFFF);
    checks++; if ({resp_cyc, resp_mis, we_log[1], mem[8], mem[10]} !== {32'd1, 1'b1, 1'b0, 8'h00, 8'h00}) begin errors++; $display("[TB] FAIL misalign_word_store: got cyc=%0d mis=%b we=%b mem8=%h mem10=%h expected cyc=1 mis=1 we=0 mem=00", resp_cyc, resp_mis, we_log[1], mem[8], mem[10]); end
  endtask

  task automatic test_reset_mid();
    int resp_seen = 0;
    int we_seen = 0;
    @(negedge clk);
    bus.req_we_i = 1'b1; bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = 32'h08; bus.req_wdata_i = 32'h44332211; bus.req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_we_gated: got %b expected 0", bus.mem_we_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_ready: got %b expected 1", bus.req_ready_o); end
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid_o) resp_seen++;
      if (bus.mem_we_o) we_seen++;
      @(negedge clk);
      #1;
    end
    checks++; if (resp_seen !== 0 || we_seen !== 0) begin errors++; $display("[TB] FAIL reset_mid_quiet: got resp=%0d we=%0d expected 0 0", resp_seen, we_seen); end
    checks++; if ({mem[11], mem[10], mem[9], mem[8]} !== 32'h00002211) begin errors++; $display("[TB] FAIL reset_mid_mem: got %h expected 00002211", {mem[11], mem[10], mem[9], mem[8]}); end
  endtask

  task automatic test_bounds();
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h87654321);
`ifdef LSU_BOUNDS_CHECK_EN
    checks++; if ({resp_cyc, resp_fault, resp_mis, we_log[1]} !== {32'd1, 1'b1, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL bounds_fault: got cyc=%0d fault=%b mis=%b we=%b expected cyc=1 fault=1 mis=0 we=0", resp_cyc, resp_fault, resp_mis, we_log[1]); end
    checks++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h0) begin errors++; $display("[TB] FAIL bounds_mem: got %h expected 00000000", {mem[3], mem[2], mem[1], mem[0]}); end
`else
    checks++; if ({resp_cyc, resp_fault, resp_mis} !== {32'd5, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL wrap_resp: got cyc=%0d fault=%b mis=%b expected cyc=5 fault=0 mis=0", resp_cyc, resp_fault, resp_mis); end
    checks++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h87654321) begin errors++; $display("[TB] FAIL wrap_mem: got %h expected 87654321", {mem[3], mem[2], mem[1], mem[0]}); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_stall = 9'b011111011;
    logic [8:0] exp_ready = 9'b000001000;
    logic [8:0] exp_resp  = 9'b100000100;
    logic [8:0] got_stall = '0;
    logic [8:0] got_ready = '0;
    logic [8:0] got_resp  = '0;
    logic [31:0] first_data = 32'h0;
    @(negedge clk);
    bus.req_we_i = 1'b0; bus.req_size_i = 2'b00; bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = 32'h07; bus.req_wdata_i = 32'h0; bus.req_valid_i = 1'b1;
    #1;
    checks++; if ({bus.stall_o, bus.req_ready_o} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_idle_stall_ready: got %b expected 11", {bus.stall_o, bus.req_ready_o}); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #1;
      got_stall[k-1] = bus.stall_o; got_ready[k-1] = bus.req_ready_o; got_resp[k-1] = bus.resp_valid_o;
      if (k == 3) begin
        first_data = bus.resp_rdata_o;
        bus.req_we_i = 1'b1; bus.req_size_i = 2'b10; bus.req_addr_i = 32'h18; bus.req_wdata_i = 32'h01020304;
      end
      if (k == 9) bus.req_valid_i = 1'b0;
    end
    checks++; if (got_stall !== exp_stall) begin errors++; $display("[TB] FAIL b2b_stall: got %b expected %b", got_stall, exp_stall); end
    checks++; if (got_ready !== exp_ready) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected %b", got_ready, exp_ready); end
    checks++; if (got_resp !== exp_resp) begin errors++; $display("[TB] FAIL b2b_resp: got %b expected %b", got_resp, exp_resp); end
    checks++; if (first_data !== 32'hFFFFFFDE) begin errors++; $display("[TB] FAIL b2b_first_data: got %h expected FFFFFFDE", first_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_after: got %b expected 0", bus.stall_o); end
    checks++; if ({mem[27], mem[26], mem[25], mem[24]} !== 32'h01020304) begin errors++; $display("[TB] FAIL b2b_mem: got %h expected 01020304", {mem[27], mem[26], mem[25], mem[24]}); end
  endtask

  // Scenario sequence; each task checks its own expectations
  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_misalign();
    test_reset_mid();
    test_bounds();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
